// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the two write requesters, the arbiter and the register-file write port.
interface regfile_write_arbiter_if;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              reqA_valid;
  logic [SEL_W-1:0]  reqA_sel;
  logic [DATA_W-1:0] reqA_data;
  logic              reqA_ready;
  logic              reqB_valid;
  logic [SEL_W-1:0]  reqB_sel;
  logic [DATA_W-1:0] reqB_data;
  logic              reqB_ready;
  logic              writeEnable;
  logic [SEL_W-1:0]  writeSel;
  logic [DATA_W-1:0] writeData;
  logic              busy;

  modport master (
    output reqA_valid, reqA_sel, reqA_data,
    output reqB_valid, reqB_sel, reqB_data,
    input  reqA_ready, reqB_ready,
    input  writeEnable, writeSel, writeData, busy
  );

  modport slave (
    input  reqA_valid, reqA_sel, reqA_data,
    input  reqB_valid, reqB_sel, reqB_data,
    output reqA_ready, reqB_ready,
    output writeEnable, writeSel, writeData, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single 32x32 register-file write port (A = writeback, B = load).
// Build option RF_CLEAR_ON_RESET_EN adds a 32-cycle clear sweep (INIT state) after reset.
module regfile_write_arbiter (
  input  logic                  clock,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              run_c;
  logic              grant_a_c;
  logic              grant_b_c;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_b_q, last_b_d;

`ifdef RF_CLEAR_ON_RESET_EN
  localparam logic [0:0]       ST_INIT  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(31);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;

  assign run_c    = (state_q == ST_RUN);
  assign bus.busy = (state_q == ST_INIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign run_c    = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // Grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (run_c) begin
      if (bus.reqA_valid && bus.reqB_valid) begin
        grant_a_c = last_b_q;
        grant_b_c = !last_b_q;
      end else begin
        grant_a_c = bus.reqA_valid;
        grant_b_c = bus.reqB_valid;
      end
    end
  end

  assign bus.reqA_ready = grant_a_c;
  assign bus.reqB_ready = grant_b_c;

  always_comb begin
    we_d     = 1'b0;
    sel_d    = sel_q;
    data_d   = data_q;
    last_b_d = last_b_q;
`ifdef RF_CLEAR_ON_RESET_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
`endif
    if (grant_a_c) begin
      we_d     = (bus.reqA_sel != '0);
      sel_d    = bus.reqA_sel;
      data_d   = bus.reqA_data;
      last_b_d = 1'b0;
    end else if (grant_b_c) begin
      we_d     = (bus.reqB_sel != '0);
      sel_d    = bus.reqB_sel;
      data_d   = bus.reqB_data;
      last_b_d = 1'b1;
    end
`ifdef RF_CLEAR_ON_RESET_EN
    // Sweep holds at 31 rather than wrapping; the last sweep write hands over to RUN.
    if (state_q == ST_INIT) begin
      we_d   = 1'b1;
      sel_d  = cnt_q;
      data_d = '0;
      if (cnt_q == LAST_SEL) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + SEL_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q     <= 1'b0;
      sel_q    <= '0;
      data_q   <= '0;
      last_b_q <= 1'b1;
    end else begin
      we_q     <= we_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      last_b_q <= last_b_d;
    end
  end

  assign bus.writeEnable = we_q;
  assign bus.writeSel    = sel_q;
  assign bus.writeData   = data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default build and RF_CLEAR_ON_RESET_EN).
module tb_regfile_write_arbiter;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

`ifdef RF_CLEAR_ON_RESET_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  task automatic drive(input logic av, input logic [4:0] as, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bs, input logic [31:0] bd);
    bus.reqA_valid = av;
    bus.reqA_sel   = as;
    bus.reqA_data  = ad;
    bus.reqB_valid = bv;
    bus.reqB_sel   = bs;
    bus.reqB_data  = bd;
  endtask

  // Reset for one edge, release at a negedge; with the sweep built, wait it out.
  task automatic reset_to_run();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
`ifdef RF_CLEAR_ON_RESET_EN
    repeat (32) @(posedge clock);
    #1;
`endif
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", bus.writeEnable); end
    n_cmp++;
    if (bus.writeSel !== 5'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", bus.writeSel); end
    n_cmp++;
    if (bus.writeData !== 32'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", bus.writeData); end
    n_cmp++;
    if (bus.busy !== EXP_BUSY_RST) begin n_bad++; $display("FAIL reset_busy got %b want %b", bus.busy, EXP_BUSY_RST); end
    n_cmp++;
    if ({bus.reqA_ready, bus.reqB_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready got %b%b want 00", bus.reqA_ready, bus.reqB_ready);
    end
  endtask

`ifdef RF_CLEAR_ON_RESET_EN
  task automatic test_sweep();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.reqA_ready !== 1'b0 || bus.reqB_ready !== 1'b0) begin
        n_bad++; $display("FAIL sweep_busy[%0d] got busy=%b rdy=%b%b want busy=1 rdy=00",
                          i, bus.busy, bus.reqA_ready, bus.reqB_ready);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.writeEnable !== 1'b1 || bus.writeSel !== 5'(i) || bus.writeData !== 32'd0) begin
        n_bad++; $display("FAIL sweep_write[%0d] got we=%b sel=%0d data=%h want we=1 sel=%0d data=0",
                          i, bus.writeEnable, bus.writeSel, bus.writeData, i);
      end
      @(negedge clock);
    end
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL sweep_done_busy got %b want 0", bus.busy); end
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b0 || bus.writeSel !== 5'd31) begin
      n_bad++; $display("FAIL sweep_after got we=%b sel=%0d want we=0 sel=31", bus.writeEnable, bus.writeSel);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeSel !== 5'd10) begin n_bad++; $display("FAIL midsweep_pre got sel=%0d want 10", bus.writeSel); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b0 || bus.writeSel !== 5'd0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL midsweep_reset got we=%b sel=%0d busy=%b want we=0 sel=0 busy=1",
                        bus.writeEnable, bus.writeSel, bus.busy);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.writeEnable !== 1'b1 || bus.writeSel !== 5'(i)) begin
        n_bad++; $display("FAIL midsweep_restart[%0d] got we=%b sel=%0d want we=1 sel=%0d",
                          i, bus.writeEnable, bus.writeSel, i);
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midsweep_done got busy=%b want 0", bus.busy); end
  endtask
`else
  task automatic test_first_cycle();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.reqA_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL first_cycle_ready got rdyA=%b busy=%b want rdyA=1 busy=0", bus.reqA_ready, bus.busy);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b1 || bus.writeSel !== 5'd3 || bus.writeData !== 32'h0000_0033) begin
      n_bad++; $display("FAIL first_cycle_write got we=%b sel=%0d data=%h want we=1 sel=3 data=33",
                        bus.writeEnable, bus.writeSel, bus.writeData);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask
`endif

  task automatic test_single();
    reset_to_run();
    @(negedge clock);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++;
    if (bus.reqA_ready !== 1'b1 || bus.reqB_ready !== 1'b0) begin
      n_bad++; $display("FAIL single_ready got %b%b want 10", bus.reqA_ready, bus.reqB_ready);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b1 || bus.writeSel !== 5'd5 || bus.writeData !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL single_write got we=%b sel=%0d data=%h want we=1 sel=5 data=deadbeef",
                        bus.writeEnable, bus.writeSel, bus.writeData);
    end
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b0 || bus.writeSel !== 5'd5 || bus.writeData !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL single_idle got we=%b sel=%0d data=%h want we=0 sel=5 data=deadbeef",
                        bus.writeEnable, bus.writeSel, bus.writeData);
    end
  endtask

  // Fresh reset, then five tied cycles: A,B,A,B,A with writes 1,2,1,2,1 back to back.
  task automatic test_back_to_back();
    logic       exp_a;
    logic [4:0] exp_sel;
    reset_to_run();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      exp_a   = (i % 2 == 0);
      exp_sel = exp_a ? 5'd1 : 5'd2;
      #1;
      n_cmp++;
      if (bus.reqA_ready !== exp_a || bus.reqB_ready !== !exp_a) begin
        n_bad++; $display("FAIL rr_grant[%0d] got %b%b want %b%b", i, bus.reqA_ready, bus.reqB_ready, exp_a, !exp_a);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.writeEnable !== 1'b1 || bus.writeSel !== exp_sel || bus.writeData !== 32'(exp_a ? 32'h11 : 32'h22)) begin
        n_bad++; $display("FAIL rr_write[%0d] got we=%b sel=%0d data=%h want we=1 sel=%0d",
                          i, bus.writeEnable, bus.writeSel, bus.writeData, exp_sel);
      end
    end
  endtask

  // Last grant was A; a sel==0 B transfer must move the pointer so the next tie goes to A.
  task automatic test_zero_write();
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    n_cmp++;
    if (bus.reqB_ready !== 1'b1 || bus.reqA_ready !== 1'b0) begin
      n_bad++; $display("FAIL zero_ready got %b%b want 01", bus.reqA_ready, bus.reqB_ready);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b0) begin n_bad++; $display("FAIL zero_we got %b want 0", bus.writeEnable); end
    @(negedge clock);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    #1;
    n_cmp++;
    if (bus.reqA_ready !== 1'b1 || bus.reqB_ready !== 1'b0) begin
      n_bad++; $display("FAIL zero_ptr got %b%b want 10", bus.reqA_ready, bus.reqB_ready);
    end
    @(posedge clock);
  endtask

  // Idle cycle after an A grant: outputs hold, pointer holds, next tie goes to B.
  task automatic test_idle();
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++;
    if ({bus.reqA_ready, bus.reqB_ready} !== 2'b00) begin
      n_bad++; $display("FAIL idle_ready got %b%b want 00", bus.reqA_ready, bus.reqB_ready);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b0 || bus.writeSel !== 5'd4 || bus.writeData !== 32'h44) begin
      n_bad++; $display("FAIL idle_hold got we=%b sel=%0d data=%h want we=0 sel=4 data=44",
                        bus.writeEnable, bus.writeSel, bus.writeData);
    end
    @(negedge clock);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    #1;
    n_cmp++;
    if (bus.reqA_ready !== 1'b0 || bus.reqB_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_ptr got %b%b want 01", bus.reqA_ready, bus.reqB_ready);
    end
    @(posedge clock);
  endtask

  // Reset while a request is being accepted: the write is dropped and pointer returns to B.
  task automatic test_reset_mid_stream();
    @(negedge clock);
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b0 || bus.writeSel !== 5'd0 || bus.writeData !== 32'd0) begin
      n_bad++; $display("FAIL midstream_reset got we=%b sel=%0d data=%h want we=0 sel=0 data=0",
                        bus.writeEnable, bus.writeSel, bus.writeData);
    end
    @(negedge clock);
    reset = 1'b0;
`ifdef RF_CLEAR_ON_RESET_EN
    repeat (32) @(posedge clock);
    @(negedge clock);
`endif
    #1;
    n_cmp++;
    if (bus.reqA_ready !== 1'b1 || bus.reqB_ready !== 1'b0) begin
      n_bad++; $display("FAIL midstream_ptr got %b%b want 10", bus.reqA_ready, bus.reqB_ready);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (bus.writeEnable !== 1'b1 || bus.writeSel !== 5'd7 || bus.writeData !== 32'h77) begin
      n_bad++; $display("FAIL midstream_write got we=%b sel=%0d data=%h want we=1 sel=7 data=77",
                        bus.writeEnable, bus.writeSel, bus.writeData);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    n_cmp = 0;
    n_bad = 0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    test_reset();
`ifdef RF_CLEAR_ON_RESET_EN
    test_sweep();
    test_reset_mid_sweep();
`else
    test_first_cycle();
`endif
    test_single();
    test_back_to_back();
    test_zero_write();
    test_idle();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
